// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl
// -----------------
// Bit-serial WIDTH-bit adder controller. One full-adder slice, built from two
// half-adder stages, is reused across WIDTH clock cycles. The slice is stepped
// LSB-first with a registered carry. The result is presented on a registered
// sum with a one-cycle done pulse.
//
// Optional feature macro: SERIAL_ADDER_COUT_EN
//   defined   : cout port and its register exist. cout carries bit WIDTH of
//               a+b and is valid together with done.
//   undefined : no cout port. Sum behaviour and timing are unchanged.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous active-high reset
//   start_valid  requester presents an operand pair
//   start_ready  job can be accepted (IDLE only, low while rst is high)
//   a, b         operands, sampled only on acceptance
//   sum          registered result, held until the next acceptance
//   cout         registered MSB carry-out (SERIAL_ADDER_COUT_EN only)
//   done         one-cycle pulse: sum (and cout) valid
//   busy         high in ADD and DONE
module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_valid,
  output logic             start_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
`ifdef SERIAL_ADDER_COUT_EN
  output logic             cout,
`endif
  output logic             done,
  output logic             busy
);

  // One extra bit keeps the counter from wrapping at WIDTH-1 for power-of-two widths.
  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADD  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] opa_r;
  logic [WIDTH-1:0] opb_r;
  logic [WIDTH-1:0] sum_r;
  logic             c_r;
  logic [CNT_W-1:0] cnt_r;
  logic             done_r;
  logic             busy_r;
`ifdef SERIAL_ADDER_COUT_EN
  logic             cout_r;
`endif

  logic p_s;
  logic g1_s;
  logic s_s;
  logic g2_s;
  logic carry_next_s;

  // Half adder: returns {carry, sum}.
  function automatic logic [1:0] half_add(input logic x, input logic y);
    return {x & y, x ^ y};
  endfunction

  // Shared full-adder slice: two chained half adders on the current LSBs and the carry.
  always_comb begin
    p_s          = 1'b0;
    g1_s         = 1'b0;
    s_s          = 1'b0;
    g2_s         = 1'b0;
    {g1_s, p_s}  = half_add(opa_r[0], opb_r[0]);
    {g2_s, s_s}  = half_add(p_s, c_r);
    carry_next_s = g1_s | g2_s;
  end

  // Ready is decoded from the state register and is masked during reset.
  // It has no dependency on start_valid.
  assign start_ready = (state_r == IDLE) && !rst;

  // Controller FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
      opa_r   <= {WIDTH{1'b0}};
      opb_r   <= {WIDTH{1'b0}};
      sum_r   <= {WIDTH{1'b0}};
      c_r     <= 1'b0;
      cnt_r   <= {CNT_W{1'b0}};
      done_r  <= 1'b0;
      busy_r  <= 1'b0;
`ifdef SERIAL_ADDER_COUT_EN
      cout_r  <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (start_valid) begin
            opa_r   <= a;
            opb_r   <= b;
            sum_r   <= {WIDTH{1'b0}};
            c_r     <= 1'b0;
            cnt_r   <= {CNT_W{1'b0}};
            busy_r  <= 1'b1;
            state_r <= ADD;
          end else begin
            busy_r  <= 1'b0;
          end
          done_r <= 1'b0;
        end
        ADD: begin
          // The sum fills from the top, so bit 0 lands at position 0 after WIDTH shifts.
          sum_r <= {s_s, sum_r[WIDTH-1:1]};
          opa_r <= {1'b0, opa_r[WIDTH-1:1]};
          opb_r <= {1'b0, opb_r[WIDTH-1:1]};
          c_r   <= carry_next_s;
          cnt_r <= cnt_r + CNT_W'(1);
          if (cnt_r == LAST_CNT) begin
            done_r  <= 1'b1;
`ifdef SERIAL_ADDER_COUT_EN
            // The carry produced by the MSB slice is the true carry-out.
            cout_r  <= carry_next_s;
`endif
            state_r <= DONE;
          end else begin
            done_r  <= 1'b0;
          end
        end
        DONE: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          done_r  <= 1'b0;
          busy_r  <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign sum  = sum_r;
  assign done = done_r;
  assign busy = busy_r;
`ifdef SERIAL_ADDER_COUT_EN
  assign cout = cout_r;
`endif

endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl
// --------------------
// Self-checking bench for serial_adder_ctrl. It uses two instances, WIDTH=8 and
// WIDTH=2. Expected {cout,sum} values are pushed to a queue when a job is
// accepted, and popped and compared when done pulses. Inputs change and outputs
// are sampled on the falling clock edge. cout checks apply only when
// SERIAL_ADDER_COUT_EN is defined.
module tb_serial_adder_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;

  logic       sv8 = 1'b0;
  logic [7:0] a8  = 8'h00;
  logic [7:0] b8  = 8'h00;
  logic       sr8;
  logic [7:0] sum8;
  logic       done8;
  logic       busy8;

  logic       sv2 = 1'b0;
  logic [1:0] a2  = 2'b00;
  logic [1:0] b2  = 2'b00;
  logic       sr2;
  logic [1:0] sum2;
  logic       done2;
  logic       busy2;
`ifdef SERIAL_ADDER_COUT_EN
  logic       cout8;
  logic       cout2;
`endif

  int checks = 0;
  int errors = 0;

  logic [8:0] q8[$];
  logic [2:0] q2[$];

  always #5 clk = ~clk;

  serial_adder_ctrl #(.WIDTH(8)) dut8 (
    .clk(clk), .rst(rst), .start_valid(sv8), .start_ready(sr8),
    .a(a8), .b(b8), .sum(sum8),
`ifdef SERIAL_ADDER_COUT_EN
    .cout(cout8),
`endif
    .done(done8), .busy(busy8)
  );

  serial_adder_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_valid(sv2), .start_ready(sr2),
    .a(a2), .b(b2), .sum(sum2),
`ifdef SERIAL_ADDER_COUT_EN
    .cout(cout2),
`endif
    .done(done2), .busy(busy2)
  );

  // Watchdog: the run must never hang.
  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Present a job to the 8-bit DUT and push its expected result when accepted.
  // Returns on the falling edge after the acceptance edge.
  task automatic issue8(input logic [7:0] x, input logic [7:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    a8 = x; b8 = y; sv8 = 1'b1;
    while (sr8 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sr8 !== 1'b1) begin
      errors++;
      $display("FAIL accept8 start_ready=%b required 1", sr8);
    end else begin
      q8.push_back({1'b0, x} + {1'b0, y});
    end
    @(negedge clk);
    sv8 = 1'b0;
  endtask

  // Present a job to the 2-bit DUT and push its expected result when accepted.
  task automatic issue2(input logic [1:0] x, input logic [1:0] y);
    int guard;
    guard = 0;
    @(negedge clk);
    a2 = x; b2 = y; sv2 = 1'b1;
    while (sr2 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (sr2 !== 1'b1) begin
      errors++;
      $display("FAIL accept2 start_ready=%b required 1", sr2);
    end else begin
      q2.push_back({1'b0, x} + {1'b0, y});
    end
    @(negedge clk);
    sv2 = 1'b0;
  endtask

  // Count falling edges until done8 is seen (bounded).
  task automatic wait_done8(output int cyc);
    cyc = 0;
    while (done8 !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  // Count falling edges until done2 is seen (bounded).
  task automatic wait_done2(output int cyc);
    cyc = 0;
    while (done2 !== 1'b1 && cyc < 64) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks += 4;
    if (sr8 !== 1'b0)    begin errors++; $display("FAIL rst_ready got %b required 0", sr8); end
    if (done8 !== 1'b0)  begin errors++; $display("FAIL rst_done got %b required 0", done8); end
    if (busy8 !== 1'b0)  begin errors++; $display("FAIL rst_busy got %b required 0", busy8); end
    if (sum8 !== 8'h00)  begin errors++; $display("FAIL rst_sum got %h required 00", sum8); end
    rst = 1'b0;
    @(negedge clk);
    checks += 5;
    if (sr8 !== 1'b1)    begin errors++; $display("FAIL idle_ready got %b required 1", sr8); end
    if (sr2 !== 1'b1)    begin errors++; $display("FAIL idle_ready2 got %b required 1", sr2); end
    if (sum8 !== 8'h00)  begin errors++; $display("FAIL idle_sum got %h required 00", sum8); end
    if (done8 !== 1'b0)  begin errors++; $display("FAIL idle_done got %b required 0", done8); end
    if (busy8 !== 1'b0)  begin errors++; $display("FAIL idle_busy got %b required 0", busy8); end
`ifdef SERIAL_ADDER_COUT_EN
    checks++;
    if (cout8 !== 1'b0)  begin errors++; $display("FAIL idle_cout got %b required 0", cout8); end
`endif
  endtask

  task automatic test_basic;
    int cyc;
    int busy_n;
    logic [8:0] expv;
    issue8(8'h5A, 8'h25);
    cyc = 0; busy_n = 0;
    while (done8 !== 1'b1 && cyc < 64) begin
      if (busy8 === 1'b1) busy_n++;
      @(negedge clk);
      cyc++;
    end
    if (busy8 === 1'b1) busy_n++;
    checks += 3;
    if (cyc != 8)      begin errors++; $display("FAIL basic_latency got %0d required 8", cyc); end
    if (busy_n != 9)   begin errors++; $display("FAIL basic_busy_cycles got %0d required 9", busy_n); end
    expv = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    if (sum8 !== expv[7:0]) begin errors++; $display("FAIL basic_sum got %h required %h", sum8, expv[7:0]); end
`ifdef SERIAL_ADDER_COUT_EN
    checks++;
    if (cout8 !== expv[8]) begin errors++; $display("FAIL basic_cout got %b required %b", cout8, expv[8]); end
`endif
    @(negedge clk);
    checks += 4;
    if (done8 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b required 0", done8); end
    if (busy8 !== 1'b0) begin errors++; $display("FAIL basic_busy_after got %b required 0", busy8); end
    if (sr8 !== 1'b1)   begin errors++; $display("FAIL basic_ready_after got %b required 1", sr8); end
    if (sum8 !== 8'h7F) begin errors++; $display("FAIL basic_sum_hold got %h required 7f", sum8); end
  endtask

  task automatic test_carry;
    logic [7:0] va[4];
    logic [7:0] vb[4];
    int cyc;
    logic [8:0] expv;
    va[0] = 8'hFF; vb[0] = 8'h01;
    va[1] = 8'h80; vb[1] = 8'h80;
    va[2] = 8'hFF; vb[2] = 8'hFF;
    va[3] = 8'h00; vb[3] = 8'h00;
    for (int i = 0; i < 4; i++) begin
      issue8(va[i], vb[i]);
      wait_done8(cyc);
      expv = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
      checks += 2;
      if (cyc != 8) begin errors++; $display("FAIL carry_latency[%0d] got %0d required 8", i, cyc); end
      if (sum8 !== expv[7:0]) begin errors++; $display("FAIL carry_sum[%0d] got %h required %h", i, sum8, expv[7:0]); end
`ifdef SERIAL_ADDER_COUT_EN
      checks++;
      if (cout8 !== expv[8]) begin errors++; $display("FAIL carry_cout[%0d] got %b required %b", i, cout8, expv[8]); end
`endif
    end
  endtask

  task automatic test_back_to_back;
    int guard;
    int n_done;
    time t1;
    time t2;
    logic acc2;
    logic [8:0] expv;
    guard = 0; n_done = 0; acc2 = 1'b0; t1 = 0; t2 = 0;
    @(negedge clk);
    a8 = 8'h01; b8 = 8'h02; sv8 = 1'b1;
    while (sr8 !== 1'b1 && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    q8.push_back(9'h003);
    for (int k = 0; k < 30; k++) begin
      @(negedge clk);
      if (done8 === 1'b1) begin
        expv = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
        checks++;
        if (sum8 !== expv[7:0]) begin errors++; $display("FAIL b2b_sum[%0d] got %h required %h", n_done, sum8, expv[7:0]); end
        if (n_done == 0) t1 = $time; else t2 = $time;
        n_done++;
      end
      if (sr8 === 1'b1 && !acc2) begin
        a8 = 8'h10; b8 = 8'h20;
        q8.push_back(9'h030);
        acc2 = 1'b1;
      end else begin
        a8 = 8'($urandom);
        b8 = 8'($urandom);
        if (acc2) sv8 = 1'b0;
      end
    end
    sv8 = 1'b0;
    checks += 2;
    if (n_done != 2) begin errors++; $display("FAIL b2b_done_count got %0d required 2", n_done); end
    if ((t2 - t1) != 100) begin errors++; $display("FAIL b2b_spacing got %0t required 100", t2 - t1); end
  endtask

  task automatic test_reset_mid;
    int cyc;
    logic seen;
    logic [8:0] expv;
    issue8(8'hF0, 8'h0F);
    expv = q8.pop_back();
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks += 4;
    if (busy8 !== 1'b0) begin errors++; $display("FAIL rmid_busy got %b required 0", busy8); end
    if (done8 !== 1'b0) begin errors++; $display("FAIL rmid_done got %b required 0", done8); end
    if (sum8 !== 8'h00) begin errors++; $display("FAIL rmid_sum got %h required 00", sum8); end
    if (sr8 !== 1'b0)   begin errors++; $display("FAIL rmid_ready got %b required 0", sr8); end
    rst = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8 === 1'b1) seen = 1'b1;
    end
    checks += 2;
    if (seen !== 1'b0)  begin errors++; $display("FAIL rmid_no_done got %b required 0", seen); end
    if (sum8 !== 8'h00) begin errors++; $display("FAIL rmid_sum_after got %h required 00", sum8); end
    issue8(8'h0F, 8'h0F);
    wait_done8(cyc);
    expv = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
    checks += 2;
    if (sum8 !== expv[7:0]) begin errors++; $display("FAIL rmid_next_sum got %h required %h", sum8, expv[7:0]); end
    if (sum8 !== 8'h1E)     begin errors++; $display("FAIL rmid_next_1e got %h required 1e", sum8); end
  endtask

  task automatic test_random8;
    int cyc;
    logic [8:0] expv;
    for (int i = 0; i < 1000; i++) begin
      issue8(8'($urandom), 8'($urandom));
      wait_done8(cyc);
      expv = (q8.size() != 0) ? q8.pop_front() : 9'h1FF;
      checks += 2;
      if (cyc != 8) begin errors++; $display("FAIL rand8_latency[%0d] got %0d required 8", i, cyc); end
      if (sum8 !== expv[7:0]) begin errors++; $display("FAIL rand8_sum[%0d] got %h required %h", i, sum8, expv[7:0]); end
`ifdef SERIAL_ADDER_COUT_EN
      checks++;
      if (cout8 !== expv[8]) begin errors++; $display("FAIL rand8_cout[%0d] got %b required %b", i, cout8, expv[8]); end
`endif
    end
  endtask

  task automatic test_random2;
    int cyc;
    logic [2:0] expv;
    for (int i = 0; i < 1000; i++) begin
      issue2(2'($urandom), 2'($urandom));
      wait_done2(cyc);
      expv = (q2.size() != 0) ? q2.pop_front() : 3'b111;
      checks += 2;
      if (cyc != 2) begin errors++; $display("FAIL rand2_latency[%0d] got %0d required 2", i, cyc); end
      if (sum2 !== expv[1:0]) begin errors++; $display("FAIL rand2_sum[%0d] got %h required %h", i, sum2, expv[1:0]); end
`ifdef SERIAL_ADDER_COUT_EN
      checks++;
      if (cout2 !== expv[2]) begin errors++; $display("FAIL rand2_cout[%0d] got %b required %b", i, cout2, expv[2]); end
`endif
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_carry();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    test_random2();
    checks++;
    if (q8.size() != 0 || q2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain got %0d/%0d required 0/0", q8.size(), q2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
